// File: rtl/spi_flash_pkg.sv
// Shared definitions for the EN25F80 read-only SPI flash controller.
// Build option: define SPI_FLASH_FAST_READ_EN to issue FAST READ (0x0B) with
// eight dummy clocks instead of plain READ (0x03).
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } state_t;

`ifdef SPI_FLASH_FAST_READ_EN
    // opcode + 24-bit address + 8 dummy clocks + 32 data bits
    localparam int SHIFT_BITS = 72;
`else
    // opcode + 24-bit address + 32 data bits
    localparam int SHIFT_BITS = 64;
`endif

    // Complete MOSI frame for one word read; the trailing zeros are
    // clocked out while the data word comes back on MISO.
    function automatic logic [SHIFT_BITS-1:0] build_frame(input logic [31:0] addr);
`ifdef SPI_FLASH_FAST_READ_EN
        build_frame = {OP_FAST_READ, 4'h0, addr[19:2], 2'b00, 8'h00, 32'h0};
`else
        build_frame = {OP_READ, 4'h0, addr[19:2], 2'b00, 32'h0};
`endif
    endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SCK generator, bit counter and MOSI/MISO shift registers for one SPI frame.
// The frame length is set by SHIFT_BITS (FAST READ when SPI_FLASH_FAST_READ_EN
// is defined). SPI mode 0: SCK idles low, MISO is sampled on the rising edge,
// MOSI advances on the falling edge.
module spi_flash_shifter
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int WIDTH   = SHIFT_BITS
) (
    input  logic             clkMain,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [6:0]       bits,
    input  logic             miso,
    output logic             sck,
    output logic             mosi,
    output logic             done,
    output logic [31:0]      rx_word
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic             active_reg;
    logic             sck_reg;
    logic [15:0]      div_cnt_reg;
    logic [6:0]       bit_cnt_reg;
    logic [WIDTH-1:0] tx_reg;
    logic [31:0]      rx_reg;
    logic             half_end;

    // Last clkMain cycle of the current SCK half period.
    assign half_end = active_reg && (div_cnt_reg == DIV_LAST);
    // Asserted in the cycle whose closing edge is the final falling SCK edge.
    assign done     = half_end && sck_reg && (bit_cnt_reg == bits - 7'd1);

    assign sck  = sck_reg;
    assign mosi = tx_reg[WIDTH-1];

    // First received byte sits in rx_reg[31:24]; present it little-endian.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_swap
            assign rx_word[8*gi +: 8] = rx_reg[8*(3-gi) +: 8];
        end
    endgenerate

    // Divider, SCK toggling and both shift registers.
    always_ff @(posedge clkMain) begin
        if (rst) begin
            active_reg  <= 1'b0;
            sck_reg     <= 1'b0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
        end else begin
            if (load) begin
                tx_reg <= load_data;
            end
            if (start) begin
                active_reg  <= 1'b1;
                sck_reg     <= 1'b0;
                div_cnt_reg <= '0;
                bit_cnt_reg <= '0;
            end else if (active_reg) begin
                if (half_end) begin
                    div_cnt_reg <= '0;
                    sck_reg     <= ~sck_reg;
                    if (!sck_reg) begin
                        rx_reg <= {rx_reg[30:0], miso};
                    end else begin
                        tx_reg      <= {tx_reg[WIDTH-2:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 7'd1;
                        if (done) begin
                            active_reg <= 1'b0;
                        end
                    end
                end else begin
                    div_cnt_reg <= div_cnt_reg + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_ctrl.sv
// Read-only EN25F80 controller: one CPU word read becomes one SPI READ frame,
// with the CPU stalled through busy_o until the word is assembled.
// Build option: SPI_FLASH_FAST_READ_EN selects FAST READ with dummy clocks.
module spi_flash_ctrl
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_HIGH = 4
) (
    input  logic        clkMain,
    input  logic        rst,
    input  logic        devEnable_i,
    input  logic        readEnable_i,
    input  logic [31:0] addr_i,
    output logic [31:0] readData_o,
    output logic        busy_o,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        spi_di,
    input  logic        spi_do
);

    localparam int          GAP_W      = (CS_HIGH < 1) ? 1 : $clog2(CS_HIGH + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_HIGH);
    localparam logic [15:0] PHASE_LAST = 16'(CLK_DIV - 1);

    state_t           state_reg, state_next;
    logic             cs_n_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [15:0]      phase_cnt_reg;
    logic [31:0]      read_data_reg;

    logic             request;
    logic             phase_last;
    logic             load, start, cs_assert, cs_release, capture;
    logic             shift_done;
    logic [31:0]      rx_word;

    assign request    = devEnable_i & readEnable_i;
    assign phase_last = (phase_cnt_reg == PHASE_LAST);

    assign busy_o     = request & (state_reg != DONE);
    assign spi_cs_n   = cs_n_reg;
    assign readData_o = read_data_reg;

    spi_flash_shifter #(
        .CLK_DIV (CLK_DIV),
        .WIDTH   (SHIFT_BITS)
    ) u_shifter (
        .clkMain   (clkMain),
        .rst       (rst),
        .load      (load),
        .load_data (build_frame(addr_i)),
        .start     (start),
        .bits      (7'(SHIFT_BITS)),
        .miso      (spi_do),
        .sck       (spi_clk),
        .mosi      (spi_di),
        .done      (shift_done),
        .rx_word   (rx_word)
    );

    // FSM state register.
    always_ff @(posedge clkMain) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        start      = 1'b0;
        cs_assert  = 1'b0;
        cs_release = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (request && (gap_cnt_reg == '0)) begin
                    load       = 1'b1;
                    cs_assert  = 1'b1;
                    state_next = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (phase_last) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    state_next = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (phase_last) begin
                    cs_release = 1'b1;
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Chip select, inter-frame gap, setup/hold timing and the read word.
    always_ff @(posedge clkMain) begin
        if (rst) begin
            cs_n_reg      <= 1'b1;
            gap_cnt_reg   <= GAP_LOAD;
            phase_cnt_reg <= '0;
            read_data_reg <= '0;
        end else begin
            if (cs_assert) begin
                cs_n_reg <= 1'b0;
            end else if (cs_release) begin
                cs_n_reg <= 1'b1;
            end

            if (cs_release) begin
                gap_cnt_reg <= GAP_LOAD;
            end else if (cs_n_reg && (gap_cnt_reg != '0)) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end

            if (state_next != state_reg) begin
                phase_cnt_reg <= '0;
            end else begin
                phase_cnt_reg <= phase_cnt_reg + 16'd1;
            end

            if (capture) begin
                read_data_reg <= rx_word;
            end
        end
    end

endmodule
